// File: rtl/nnrv_trace_pkg.sv
// nnrv_trace_pkg: shared record type, FSM states and byte-framing helper for the retire-trace transmitter
package nnrv_trace_pkg;
  localparam logic [7:0] TRACE_SYNC = 8'hA5;
  localparam int TRACE_REC_BYTES = 15;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } trace_rec_t;
  typedef enum logic {IDLE, SEND} trace_state_e;
  // Byte i of the framed record: sync, pc, instr, rd, wdata (all MSB first), then XOR of bytes 1..13.
  function automatic logic [7:0] rec_byte(trace_rec_t r, logic [3:0] i);
    logic [103:0] body;
    logic [7:0] b [16];
    body = {r.pc, r.instr, 3'b000, r.rd, r.wdata};
    b[0] = TRACE_SYNC;
    b[14] = 8'h00;
    b[15] = 8'h00;
    for (int k = 0; k < 13; k++) begin
      b[k + 1] = body[8 * (12 - k) +: 8];
      b[14] = b[14] ^ body[8 * (12 - k) +: 8];
    end
    return b[i];
  endfunction
endpackage

// File: rtl/nnrv_trace_tx_if.sv
// nnrv_trace_tx_if: retire input bus, byte stream handshake and overflow status
// master = retire stage + byte sink side; slave = the transmitter
interface nnrv_trace_tx_if;
  logic        i_ret_valid;
  logic [31:0] i_ret_pc;
  logic [31:0] i_ret_instr;
  logic [4:0]  i_ret_rd;
  logic [31:0] i_ret_wdata;
  logic        o_byte_valid;
  logic [7:0]  o_byte;
  logic        i_byte_ready;
  logic        o_overflow;
  logic [7:0]  o_drop_cnt;
  modport master (
    output i_ret_valid, i_ret_pc, i_ret_instr, i_ret_rd, i_ret_wdata, i_byte_ready,
    input  o_byte_valid, o_byte, o_overflow, o_drop_cnt
  );
  modport slave (
    input  i_ret_valid, i_ret_pc, i_ret_instr, i_ret_rd, i_ret_wdata, i_byte_ready,
    output o_byte_valid, o_byte, o_overflow, o_drop_cnt
  );
endinterface

// File: rtl/nnrv_trace_fifo.sv
// nnrv_trace_fifo: DEPTH-entry record FIFO; push when full is accepted only alongside a pop
// ports: i_clk/i_rst, i_push+i_din, i_pop, o_head (current head), o_full, o_empty
module nnrv_trace_fifo
  import nnrv_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  trace_rec_t i_din,
  input  logic       i_pop,
  output trace_rec_t o_head,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  trace_rec_t mem_q [DEPTH];
  trace_rec_t mem_d [DEPTH];
  logic do_push, do_pop;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign o_empty = wr_q == rd_q;
  assign o_full  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_head  = mem_q[rd_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = i_din;
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge i_clk) mem_q <= mem_d;
endmodule

// File: rtl/nnrv_trace_tx.sv
// nnrv_trace_tx: serializes each retired instruction into a framed, checksummed 15-byte stream
// ports: i_clk, i_rst (async, active-high), tif (slave: retire bus in, byte stream out, overflow status)
module nnrv_trace_tx
  import nnrv_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  nnrv_trace_tx_if.slave tif
);
  trace_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  trace_rec_t hold_q, hold_d, head, din;
  logic [7:0] byte_q, byte_d, drop_q, drop_d;
  logic ovf_q, ovf_d, full, empty, pop, hs, last, drop;
  assign din = {tif.i_ret_pc, tif.i_ret_instr, tif.i_ret_rd, tif.i_ret_wdata};
  nnrv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (tif.i_ret_valid),
    .i_din  (din),
    .i_pop  (pop),
    .o_head (head),
    .o_full (full),
    .o_empty(empty)
  );
  assign hs   = state_q == SEND && tif.i_byte_ready;
  assign last = idx_q == 4'(TRACE_REC_BYTES - 1);
  // reload straight from the FIFO on the final handshake so records run back to back
  assign pop  = !empty && (state_q == IDLE || (hs && last));
  assign drop = tif.i_ret_valid && full && !pop;
  always_comb begin
    hold_d  = pop ? head : hold_q;
    idx_d   = pop || (hs && last) ? 4'd0 : hs ? idx_q + 4'd1 : idx_q;
    state_d = pop ? SEND : hs && last ? IDLE : state_q;
    // the next byte is precomputed into a register so ready never reaches o_byte combinationally
    byte_d  = pop ? TRACE_SYNC : hs && !last ? rec_byte(hold_q, idx_q + 4'd1) : byte_q;
    ovf_d   = ovf_q | drop;
    drop_d  = drop_q + {7'd0, drop && drop_q != 8'hFF};
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      byte_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  assign tif.o_byte_valid = state_q == SEND;
  assign tif.o_byte       = byte_q;
  assign tif.o_overflow   = ovf_q;
  assign tif.o_drop_cnt   = drop_q;
endmodule

// File: doc/nnrv_trace_tx.md
# nnrv_trace_tx

Retire-trace transmitter for the nnrv core. It captures one record per retired instruction (pc, instr, destination register, write data) into a small FIFO. Each record is serialized as a framed, checksummed byte stream over a valid/ready byte interface, which lets a UART or debug bridge export the same per-instruction state that simulation prints. It sits beside `nnrv_top`, fed by the writeback/retire stage.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `i_clk`  in  1  clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_ret_valid`  in  1  one instruction retires this cycle.
- `i_ret_pc`  in  32  pc of the retiring instruction.
- `i_ret_instr`  in  32  instruction word.
- `i_ret_rd`  in  5  destination register index (0 = no write).
- `i_ret_wdata`  in  32  value written to rd (sent even when rd = 0).
- `o_byte_valid`  out  1  `o_byte` is valid.
- `o_byte`  out  8  stream byte.
- `i_byte_ready`  in  1  sink accepts the byte when it and `o_byte_valid` are both 1.
- `o_overflow`  out  1  sticky; set when a retire is dropped.
- `o_drop_cnt`  out  8  dropped records, saturating at 0xFF.

## Operation
- Record is 15 bytes, sent in index order 0..14:
  - 0: sync byte 0xA5.
  - 1–4: pc, MSB first.
  - 5–8: instr, MSB first.
  - 9: {3'b0, rd}.
  - 10–13: wdata, MSB first.
  - 14: checksum, the XOR of bytes 1–13.
- Push: `i_ret_valid` = 1 writes {pc, instr, rd, wdata} into the FIFO at the clock edge.
- Full FIFO:
  - A push is dropped unless a pop occurs in the same cycle; a simultaneous push and pop when full is accepted.
  - A dropped push sets `o_overflow` and increments `o_drop_cnt` (saturating).
  - Only reset clears `o_overflow` and `o_drop_cnt`.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the hold register, set idx = 0, go to SEND.
  - SEND: `o_byte_valid` = 1 and `o_byte` = byte[idx].
  - On a handshake with idx < 14: idx + 1.
  - On a handshake with idx = 14: if the FIFO is non-empty, pop the next record and set idx = 0, staying in SEND (back-to-back, no bubble). Otherwise go to IDLE.
- `o_byte_valid` is never deasserted and `o_byte` never changes while valid and not ready.
- Empty FIFO with a push in the same cycle: the pop is not possible that cycle; the record is popped the following cycle.

## Timing
- Reset values:
  - `o_byte_valid` = 0, `o_byte` = 0x00, `o_overflow` = 0, `o_drop_cnt` = 0.
  - FIFO empty, FSM IDLE, idx = 0.
- Latency: with the block idle and the FIFO empty, a retire sampled at edge N gives `o_byte_valid` = 1 with 0xA5 in cycle N+2 (FIFO push at N, pop/load at N+1).
- Throughput: 15 cycles per record with the sink always ready; sustained retire rate above 1/15 eventually overflows.
- Reset mid-record: on assertion, outputs drop to reset values immediately (asynchronous). The partial record is abandoned, the FIFO is flushed, and the next record starts with 0xA5.
- `o_byte` is registered; idx and the hold register select it with no combinational path from `i_byte_ready` to `o_byte`.
- `o_byte_valid` depends only on state, not on `i_byte_ready`.

## Structure
- Package `nnrv_trace_pkg`:
  - constants `TRACE_SYNC` = 8'hA5 and `TRACE_REC_BYTES` = 15;
  - record struct {pc, instr, rd, wdata};
  - FSM state enum {IDLE, SEND}.
- Sub-module `nnrv_trace_fifo`: synchronous FIFO with DEPTH entries of the record struct, providing full/empty, push/pop, and the full-with-pop accept rule.
- Top: FSM, idx counter, hold register, byte mux, checksum, overflow and drop-count logic.

## Test plan
- Single retire (pc 0x00000004, instr 0x00500093, rd 1, wdata 0x5), sink always ready → bytes A5 00 00 00 04 00 50 00 93 01 00 00 00 05 C3; first byte appears 2 cycles after the retire; then IDLE.
- Three consecutive retires, sink ready → 45 contiguous valid cycles with no gap; each record starts with A5 and has a correct checksum.
- Sink ready toggling every other cycle during a record → `o_byte` stable while stalled; byte sequence unchanged; valid never drops mid-record.
- Sink ready held 0, 8 retires with DEPTH 4 → first record in hold, 4 in FIFO, 3 dropped; `o_overflow` = 1, `o_drop_cnt` = 3; releasing ready emits exactly 5 records.
- Reset asserted at byte 7 of a record with 2 queued → valid 0 immediately; after release, no output until a new retire, which starts with A5.
- Retire with rd 0, wdata 0xDEADBEEF → byte 9 = 00, bytes 10–13 = DE AD BE EF, checksum correct.
